aes_encrypt_iter: RTL and testbench

Iterative AES encryption engine that reuses the team's single-round datapath (`subBytes`, `shiftRows`, `mixColumns`, `addRoundKey`) over NR clock cycles, instead of instantiating one combinational round per stage. It adds a dedicated final round with no MixColumns, a valid/ready handshake on both sides, and a round-key request port that a separate key-schedule RAM or expander answers. It sits between the block-cipher mode controller and the key store, and is parametrised for AES-128, AES-192 and AES-256 round counts.

---
 rtl/aes_encrypt_iter.sv | 150 +++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption engine: one shared round datapath reused over NR cycles,
// with a final round that bypasses MixColumns and an external round-key request port.
module aes_encrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_encrypt_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR4 = 4'(NR);

    // Byte 0 of the table sits in the top byte of the constant.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX[base -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    state_t       fsm, fsm_next;
    logic [127:0] st, st_next;
    logic [3:0]   rnd, rnd_next;
    logic [127:0] sub_out, shift_out, mix_out, round_out;

    // One S-box bank feeds both the full round and the final round.
    assign sub_out   = sub_bytes(st);
    assign shift_out = shift_rows(sub_out);
    assign mix_out   = mix_columns(shift_out);
    assign round_out = ((rnd == NR4) ? shift_out : mix_out) ^ rk;

    assign out_data = st;
    assign busy     = (fsm != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            st  <= '0;
            rnd <= '0;
        end else begin
            fsm <= fsm_next;
            st  <= st_next;
            rnd <= rnd_next;
        end
    end

    // in_ready/out_valid: a transfer happens on any rising edge where both
    // valid and ready of that side are high; valid is never withdrawn early.
    always_comb begin
        fsm_next  = fsm;
        st_next   = st;
        rnd_next  = rnd;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        case (fsm)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && in_ready) begin
                    st_next  = in_data ^ rk;
                    rnd_next = 4'd1;
                    fsm_next = RUN;
                end
            end
            RUN: begin
                rk_idx  = rnd;
                st_next = round_out;
                if (rnd == NR4) fsm_next = DONE;
                else            rnd_next = rnd + 4'd1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors at NR=10/12/14, handshake,
// backpressure, back-to-back initiation and reset-abort behaviour.
`timescale 1ns/1ps
module tb_aes_encrypt_iter;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Unit 0: NR=10, unit 1: NR=12, unit 2: NR=14.
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic [3:0]   rk_idx    [3];
    logic [127:0] rk        [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];
    logic [127:0] rk_tab    [3][15];

    assign rk[0] = rk_tab[0][rk_idx[0]];
    assign rk[1] = rk_tab[1][rk_idx[1]];
    assign rk[2] = rk_tab[2][rk_idx[2]];

    aes_encrypt_iter #(.NR(10)) u_aes10 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk(rk[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
    aes_encrypt_iter #(.NR(12)) u_aes12 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk(rk[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
    aes_encrypt_iter #(.NR(14)) u_aes14 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .rk_idx(rk_idx[2]), .rk(rk[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- key schedule model ----------------
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX[base -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic load_keys(input int u, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rk_tab[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- driver tasks (entered and left on a negedge) ----------------
    task automatic encrypt(input int u, input int nr, input logic [127:0] pt,
                           input logic [127:0] exp, input string tag);
        int cyc;
        int trace_bad;
        in_data[u]   = pt;
        in_valid[u]  = 1'b1;
        out_ready[u] = 1'b1;
        check({tag, "_in_ready"}, in_ready[u], 1);
        check({tag, "_rk_idx0"}, rk_idx[u], 0);
        @(negedge clk);
        in_valid[u] = 1'b0;
        cyc = 1;
        trace_bad = 0;
        while (!out_valid[u] && cyc < 40) begin
            if (rk_idx[u] != 4'(cyc)) trace_bad++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, nr + 1);
        check({tag, "_rk_trace"}, trace_bad, 0);
        check({tag, "_ct"}, out_data[u], exp);
        check({tag, "_done_rk_idx"}, rk_idx[u], 0);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy[u], 0);
        check({tag, "_idle_valid"}, out_valid[u], 0);
    endtask

    task automatic back_to_back();
        int cyc, acc_n, pos, trace_bad, outs, exp_idx;
        int acc_cyc[2];
        bit swap;
        load_keys(0, KEY_C1, 4);
        exp_q.push_back(CT_C1);
        exp_q.push_back(CT_B);
        in_data[0]   = PT_C;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        cyc = 0; acc_n = 0; pos = 0; trace_bad = 0; outs = 0; swap = 1'b0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        while (outs < 2 && cyc < 60) begin
            if (swap) begin
                in_data[0] = PT_B;
                swap = 1'b0;
            end
            if (acc_n == 2) in_valid[0] = 1'b0;
            if (in_valid[0] && in_ready[0]) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                pos = 0;
                if (acc_n == 1) swap = 1'b1;
            end
            exp_idx = (pos <= 10) ? pos : 0;
            if (acc_n > 0 && rk_idx[0] != 4'(exp_idx)) trace_bad++;
            if (out_valid[0]) begin
                check("b2b_ct", out_data[0], (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
                outs++;
                if (outs == 1) load_keys(0, KEY_B, 4);
            end
            @(negedge clk);
            cyc++;
            pos++;
        end
        in_valid[0] = 1'b0;
        check("b2b_outputs", outs, 2);
        check("b2b_gap", acc_cyc[1] - acc_cyc[0], 12);
        check("b2b_rk_trace", trace_bad, 0);
    endtask

    task automatic backpressure();
        int cyc;
        int bad;
        logic [127:0] held;
        in_data[1]   = PT_C;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        in_valid[1] = 1'b0;
        cyc = 1;
        while (!out_valid[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_latency", cyc, 13);
        check("bp_ct", out_data[1], CT_C2);
        held = out_data[1];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[1] !== 1'b1 || out_data[1] !== held || in_ready[1] !== 1'b0) bad++;
        end
        check("bp_hold", bad, 0);
        // A block offered on the DONE->IDLE edge must not be taken.
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        @(negedge clk);
        check("bp_release_busy", busy[1], 0);
        check("bp_release_valid", out_valid[1], 0);
        check("bp_release_in_ready", in_ready[1], 1);
        in_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_round();
        int cyc;
        in_data[0]   = PT_B;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        cyc = 1;
        while (rk_idx[0] != 4'd5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_round5", cyc, 5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy[0], 0);
        check("rst_valid", out_valid[0], 0);
        check("rst_st", out_data[0], 0);
        check("rst_rk_idx", rk_idx[0], 0);
        check("rst_in_ready_low", in_ready[0], 0);
        in_data[0]  = PT_B;
        in_valid[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid[0] = 1'b0;
        check("rst_valid_not_accepted", busy[0], 0);
        check("rst_st_still_zero", out_data[0], 0);
        @(negedge clk);
        check("rst_in_ready_high", in_ready[0], 1);
        encrypt(0, 10, PT_B, CT_B, "after_rst");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = '0;
            out_ready[u] = 1'b0;
        end
        load_keys(0, KEY_B, 4);
        load_keys(1, KEY_C2, 6);
        load_keys(2, KEY_C3, 8);
        in_valid[0] = 1'b1;
        in_data[0]  = PT_B;
        repeat (2) @(negedge clk);
        check("reset_in_ready_low", in_ready[0], 0);
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready[0], 1);
        check("reset_out_valid", out_valid[0], 0);
        check("reset_busy", busy[0], 0);
        check("reset_rk_idx", rk_idx[0], 0);
        check("reset_out_data", out_data[0], 0);

        encrypt(0, 10, PT_B, CT_B, "aes128_b");
        encrypt(1, 12, PT_C, CT_C2, "aes192_c2");
        encrypt(2, 14, PT_C, CT_C3, "aes256_c3");
        back_to_back();
        @(negedge clk);
        backpressure();
        reset_mid_round();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
